lsu_mem_initiator: RTL
======================

# lsu_mem_initiator

Load/store initiator between the CPU execute stage and the word-organised data memory. Accepts one load or store per handshake with a RISC-V fn3 code, converts it into word-aligned memory beats with byte strobes, merges and sign/zero-extends load data, and returns one response per request. Misaligned accesses are split into two beats, or faulted when the split feature is compiled out. Out-of-range addresses and illegal fn3 values are faulted without touching memory.

## Interface
- BASE_ADDR, 32'h8000_2000, first byte address of data memory
- SIZE_BYTES, 16384, data memory size; valid range is [BASE_ADDR, BASE_ADDR+SIZE_BYTES)
- clk  in  1  CPU clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1 = store, 0 = load
- req_fn3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-justified
- resp_valid  out  1  response present, held until resp_ready
- resp_ready  in  1  consumer accepts response
- resp_data  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  1 = range, fn3 or alignment fault
- mem_en  out  1  memory beat this cycle
- mem_we  out  1  beat is a write
- mem_addr  out  32  word-aligned absolute address ([1:0]=00)
- mem_wstrb  out  4  byte-lane write enables
- mem_wdata  out  32  lane-positioned write data
- mem_rdata  in  32  read word, valid the cycle after a read beat

## Operation
- States: IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP.
- IDLE: req_ready=1; on handshake, latch we/fn3/addr/wdata; fault -> RESP, else -> ACC0. No other state asserts req_ready.
- Size mask: b=0001, h=0011, w=1111; off=addr[1:0]. Split when off+size>4.
- Fault if: fn3 not legal for direction; first or last byte outside range; split with LSU_MISALIGN_EN undefined.
- ACC0: mem_en=1, mem_addr={addr[31:2],00}, mem_wstrb=(mask<<off)[3:0] for stores else 0, mem_wdata=wdata rotated left by 8*off. Load -> WAIT0; store -> ACC1 if split else RESP.
- WAIT0: capture mem_rdata into lo; -> ACC1 if split else RESP.
- ACC1: mem_addr=word0+4, mem_wstrb=mask>>(4-off), same rotated wdata. Load -> WAIT1; store -> RESP.
- WAIT1: capture mem_rdata into hi; -> RESP.
- Load merge: ({hi,lo} >> 8*off)[31:0], hi=0 if unsplit; lb/lh sign-extend from bit 7/15, lbu/lhu zero-extend.
- RESP: resp_valid=1, data/fault stable; on resp_ready -> IDLE.
- mem_en, mem_we, mem_wstrb are 0 outside ACC0/ACC1; mem_addr/mem_wdata 0 in IDLE.

## Timing
- Reset: state IDLE; req_ready=0 during reset, 1 the first cycle after release; resp_valid, resp_data, resp_fault, mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata all 0.
- Handshake at edge T. Response first asserted in cycle: fault T+1; aligned store T+2; aligned load T+3; split store T+3; split load T+5.
- Back-to-back: resp_ready high in RESP -> IDLE next cycle; next request accepted earliest one cycle after response handshake.
- Reset mid-operation aborts immediately; no further mem_en; pending response discarded.
- Range check uses 33-bit arithmetic; last byte address wrapping past 2^32 is a fault.

## Configuration
- LSU_MISALIGN_EN defined: misaligned h/hu/w accesses split into two beats as above.
- Undefined: any access with off+size>4 returns resp_fault=1 at T+1, no memory beat; ACC1/WAIT1 unreachable.

## Test plan
- sw addr 0x8000_2004 data 0xDEAD_BEEF -> one beat, mem_addr 0x8000_2004, wstrb 1111, wdata 0xDEAD_BEEF, resp_valid at T+2, fault 0.
- sb addr 0x8000_2003 data 0x0000_00A5 -> wstrb 1000, wdata 0xA500_0000; then lb same addr with mem_rdata 0xA500_0000 -> resp_data 0xFFFF_FFA5; lbu -> 0x0000_00A5.
- lw addr 0x8000_2002, mem_rdata 0x3344_xxxx then 0xxxxx_1122 (with macro) -> beats 0x8000_2000, 0x8000_2004, resp_data 0x1122_3344 at T+5; without macro -> fault at T+1, no mem_en.
- lw addr 0x8000_1FFC and sh addr 0x8000_5FFF -> resp_fault=1, resp_data 0, no mem_en; fn3=011 load -> fault.
- resp_ready held 0 for 4 cycles -> resp_valid/data stable, req_ready 0; rst_n pulsed during WAIT0 -> all outputs 0, IDLE after release.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator
// Load/store initiator between the execute stage and word-organised data memory.
// Each request becomes one or two word-aligned memory beats with byte strobes;
// load data is merged and sign/zero-extended; exactly one response per request.
// Build option: define LSU_MISALIGN_EN to split misaligned accesses into two
// beats. Left undefined, any access crossing a word boundary is faulted.
module lsu_mem_initiator #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_2000,
  parameter int unsigned SIZE_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_fn3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_fault,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP} state_t;

  // 33-bit bounds so a last byte that wraps past 2^32 can never look in range.
  localparam logic [32:0] RANGE_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] RANGE_HI = RANGE_LO + 33'(SIZE_BYTES);

  state_t      state;
  logic        we_q;
  logic [2:0]  fn3_q;
  logic [1:0]  off_q;
  logic [3:0]  mask_q;
  logic        split_q;
  logic [31:0] lo_q;

  logic [2:0]  in_size;
  logic [3:0]  in_mask;
  logic [7:0]  in_strb_wide;
  logic [32:0] in_last;
  logic        in_fn3_ok;
  logic        in_range_ok;
  logic        in_split;
  logic        in_fault;
  logic [3:0]  acc1_strb;

  // Rotate store data left by whole bytes so byte 0 lands on lane 'off'.
  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] off);
    logic [63:0] dd;
    dd = {d, d} << {off, 3'b000};
    return dd[63:32];
  endfunction

  // Align the (possibly two-word) read data to byte 0 and extend per fn3.
  function automatic logic [31:0] load_merge(input logic [2:0] fn3, input logic [1:0] off,
                                             input logic [31:0] lo, input logic [31:0] hi);
    logic [63:0] both;
    logic [31:0] raw;
    both = {hi, lo} >> {off, 3'b000};
    raw  = both[31:0];
    case (fn3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'd0, raw[7:0]};
      3'b101:  return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Decode the incoming request: size, first-beat strobes, split and fault.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    in_size   = 3'd1;
    in_mask   = 4'b0001;
    in_fn3_ok = 1'b0;
    case (req_fn3[1:0])
      2'b01:   begin in_size = 3'd2; in_mask = 4'b0011; end
      2'b10:   begin in_size = 3'd4; in_mask = 4'b1111; end
      default: begin in_size = 3'd1; in_mask = 4'b0001; end
    endcase
    case (req_fn3)
      3'b000, 3'b001, 3'b010: in_fn3_ok = 1'b1;
      3'b100, 3'b101:         in_fn3_ok = !req_we;
      default:                in_fn3_ok = 1'b0;
    endcase
    in_strb_wide = {4'b0000, in_mask} << req_addr[1:0];
    in_last      = {1'b0, req_addr} + 33'(in_size) - 33'd1;
    in_range_ok  = ({1'b0, req_addr} >= RANGE_LO) && (in_last < RANGE_HI);
    in_split     = ({1'b0, req_addr[1:0]} + in_size) > 3'd4;
`ifdef LSU_MISALIGN_EN
    in_fault     = !in_fn3_ok || !in_range_ok;
`else
    in_fault     = !in_fn3_ok || !in_range_ok || in_split;
`endif
  end

  // Second-beat strobes: the lanes of the access that spilled into word0+4.
  assign acc1_strb = mask_q >> (3'd4 - {1'b0, off_q});

  // Request FSM; every output is a register updated together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_fault <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
      we_q       <= 1'b0;
      fn3_q      <= '0;
      off_q      <= '0;
      mask_q     <= '0;
      split_q    <= 1'b0;
      lo_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            fn3_q     <= req_fn3;
            off_q     <= req_addr[1:0];
            mask_q    <= in_mask;
            split_q   <= in_split;
            if (in_fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_data  <= '0;
            end else begin
              state     <= ACC0;
              mem_en    <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wstrb <= req_we ? in_strb_wide[3:0] : 4'b0000;
              mem_wdata <= rotl_bytes(req_wdata, req_addr[1:0]);
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ACC0: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_wstrb <= 4'b0000;
          if (!we_q) begin
            state <= WAIT0;
          end else if (split_q) begin
            state     <= ACC1;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= mem_addr + 32'd4;
            mem_wstrb <= acc1_strb;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_data  <= '0;
          end
        end
        WAIT0: begin
          lo_q <= mem_rdata;
          if (split_q) begin
            state    <= ACC1;
            mem_en   <= 1'b1;
            mem_addr <= mem_addr + 32'd4;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_data  <= load_merge(fn3_q, off_q, mem_rdata, 32'd0);
          end
        end
        ACC1: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_wstrb <= 4'b0000;
          if (we_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_data  <= '0;
          end else begin
            state <= WAIT1;
          end
        end
        WAIT1: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_data  <= load_merge(fn3_q, off_q, lo_q, mem_rdata);
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_fault <= 1'b0;
            req_ready  <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
